network_sample_link: RTL

Sample-rate side of the network forward-pass handshake. Every `sample_clk` tick it issues one forward-pass request to the network clock domain as a toggle. It receives the network's completion toggle through a synchronizer, captures the result, and scales it with saturation for the eurorack output. Missed deadlines are counted, and the output is muted until the dilated caches have filled. It sits between the network core and the codec sample output.

---
 rtl/net_io_pkg.sv | 33 +++
 rtl/toggle_sync.sv | 22 ++
 rtl/network_sample_link.sv | 80 ++++++++
 3 files changed

// File: rtl/net_io_pkg.sv
// Shared constants and saturating scale helper for the sample-rate side of the network link.
package net_io_pkg;

   localparam int unsigned W_DEF           = 16;
   localparam int unsigned SHIFT_DEF       = 2;
   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned WARMUP_DEF      = 256;
   localparam int unsigned PRIME_TICKS     = SYNC_STAGES_DEF + 2;
   localparam int unsigned COUNT_W         = 16;
   localparam int unsigned CALC_W          = 64;

   // Arithmetic left shift then clamp to the signed range of a w-bit result.
   // Callers narrow the result to w bits; CALC_W must exceed w + shift.
   function automatic logic signed [CALC_W-1:0] sat_shift(
      input logic signed [CALC_W-1:0] value,
      input int unsigned              shift,
      input int unsigned              w
   );
      logic signed [CALC_W-1:0] shifted;
      logic signed [CALC_W-1:0] max_v;
      logic signed [CALC_W-1:0] min_v;
      shifted = value <<< shift;
      max_v   = (64'sd1 <<< (w - 1)) - 64'sd1;
      min_v   = -max_v - 64'sd1;
      if (shifted > max_v)
         sat_shift = max_v;
      else if (shifted < min_v)
         sat_shift = min_v;
      else
         sat_shift = shifted;
   endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer bringing a toggle from the network clock domain into sample_clk.
module toggle_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic sample_clk,
   input  logic rst,
   input  logic toggle,
   output logic synced
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge sample_clk or posedge rst) begin
      if (rst)
         stages <= '0;
      else
         stages <= (stages << 1) | SYNC_STAGES'(toggle);
   end

   assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/network_sample_link.sv
// Per-tick forward-pass request, completion capture, saturating scale, warm-up mute and overrun count.
module network_sample_link
   import net_io_pkg::*;
#(
   parameter int unsigned W           = W_DEF,
   parameter int unsigned SHIFT       = SHIFT_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned WARMUP      = WARMUP_DEF
) (
   input  logic                  sample_clk,
   input  logic                  rst,
   input  logic                  net_done_toggle,
   input  logic signed [W-1:0]   net_result,
   output logic                  start_toggle,
   output logic signed [W-1:0]   sample_out,
   output logic                  valid,
   output logic                  warm,
   output logic [COUNT_W-1:0]    overrun_count
);

   localparam int unsigned PRIME  = SYNC_STAGES + 2;
   localparam int unsigned TICK_W = $clog2(PRIME + 1);
   localparam int unsigned WARM_W = $clog2(WARMUP + 1);

   logic              synced;
   logic              done_seen;
   logic [TICK_W-1:0] tick_cnt;
   logic [WARM_W-1:0] warm_cnt;

   logic              done_edge_c;
   logic              primed_c;
   logic [TICK_W-1:0] tick_next_c;
   logic [WARM_W-1:0] warm_next_c;
   logic [W-1:0]      scaled_c;

   toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_done_sync (
      .sample_clk (sample_clk),
      .rst        (rst),
      .toggle     (net_done_toggle),
      .synced     (synced)
   );

   // Priming uses this tick's post-increment count so the first overrun can land on tick SYNC_STAGES+2.
   always_comb begin
      done_edge_c = synced ^ done_seen;
      tick_next_c = (tick_cnt == TICK_W'(PRIME)) ? tick_cnt : tick_cnt + TICK_W'(1);
      warm_next_c = (warm_cnt == WARM_W'(WARMUP)) ? warm_cnt : warm_cnt + WARM_W'(1);
      primed_c    = (tick_next_c >= TICK_W'(PRIME));
      scaled_c    = W'(sat_shift(CALC_W'(net_result), SHIFT, W));
   end

   always_ff @(posedge sample_clk or posedge rst) begin
      if (rst) begin
         start_toggle  <= 1'b0;
         sample_out    <= '0;
         valid         <= 1'b0;
         warm          <= 1'b0;
         overrun_count <= '0;
         done_seen     <= 1'b0;
         tick_cnt      <= '0;
         warm_cnt      <= '0;
      end else begin
         start_toggle <= ~start_toggle;
         tick_cnt     <= tick_next_c;
         valid        <= done_edge_c;
         if (done_edge_c) begin
            done_seen  <= synced;
            // warm here is the pre-edge value, so the capture that completes warm-up is still muted
            sample_out <= warm ? scaled_c : '0;
            warm_cnt   <= warm_next_c;
            warm       <= (warm_next_c == WARM_W'(WARMUP));
         end else if (primed_c && (overrun_count != {COUNT_W{1'b1}})) begin
            overrun_count <= overrun_count + COUNT_W'(1);
         end
      end
   end

endmodule
